// File: rtl/isa_pkg.sv
// ISA constants, FSM state encoding and instruction field positions for the decode stage.
// Holds no logic.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JMP   = 6'b000010;
    localparam logic [5:0] OP_BC    = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_MVI   = 6'b001001;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int IMM_HI   = 15;
    localparam int J_HI     = 25;

    typedef enum logic [1:0] {
        ST_SKIP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } dec_state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational JMP/BC resolution: taken flag and word-address target.
// Zero latency; no backpressure (pure function of its inputs).
module branch_resolve
    import isa_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic [31:0] rs_data,
    output logic        taken,
    output logic [31:0] target
);

    logic [5:0]  opcode;
    logic [31:0] imm_sext;
    logic        unused_rs;

    assign opcode   = ins[OPC_HI:OPC_LO];
    assign imm_sext = {{16{ins[IMM_HI]}}, ins[IMM_HI:0]};
    // Only the sign bit decides a BC; the rest of the register is not needed here.
    assign unused_rs = ^rs_data[30:0];

    always_comb begin
        taken  = 1'b0;
        target = pc + imm_sext;
        if (opcode == OP_JMP) begin
            taken  = 1'b1;
            target = {6'd0, ins[J_HI:0]};
        end else if (opcode == OP_BC) begin
            taken  = rs_data[31];
        end
    end

endmodule

// File: rtl/decode_branch_unit.sv
// IF/ID register + field decode; resolves JMP/BC into a 1-cycle br/br_pc redirect, squashing wrong-path slots.
// Latency 1 cycle slot->id_*/br; no backpressure: one slot accepted or discarded every cycle.
module decode_branch_unit
    import isa_pkg::*;
#(
    parameter int SQUASH_SLOTS = 2,
    parameter int START_SKIP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic [31:0] rs_data,
    output logic        br,
    output logic [31:0] br_pc,
    output logic [4:0]  rs_addr,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_ins,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [5:0]  id_funct,
    output logic [31:0] id_imm
);

    dec_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        capture;
    logic        redirect;
    logic        taken;
    logic [31:0] target;

    assign rs_addr = ins[RS_HI:RS_LO];

    branch_resolve u_resolve (
        .pc      (pc),
        .ins     (ins),
        .rs_data (rs_data),
        .taken   (taken),
        .target  (target)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                capture = 1'b1;
                if (taken) begin
                    redirect = 1'b1;
                    cnt_d    = 2'(SQUASH_SLOTS);
                    state_d  = ST_SQUASH;
                end
            end
            // SKIP and SQUASH both drop slots until the counter runs out.
            ST_SKIP, ST_SQUASH: begin
                if (cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SKIP;
            cnt_q    <= 2'(START_SKIP);
            br       <= 1'b0;
            br_pc    <= 32'd0;
            id_valid <= 1'b0;
            id_pc    <= 32'd0;
            id_ins   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br       <= redirect;
            if (redirect) begin
                br_pc <= target;
            end
            id_valid <= capture;
            id_pc    <= pc;
            id_ins   <= capture ? ins : 32'd0;
        end
    end

    assign id_opcode = id_ins[OPC_HI:OPC_LO];
    assign id_rs     = id_ins[RS_HI:RS_LO];
    assign id_rt     = id_ins[RT_HI:RT_LO];
    assign id_rd     = id_ins[RD_HI:RD_LO];
    assign id_funct  = id_ins[FUNCT_HI:0];
    assign id_imm    = {{16{id_ins[IMM_HI]}}, id_ins[IMM_HI:0]};

endmodule

// File: tb/tb_decode_branch_unit.sv
// Directed test of decode_branch_unit: stimulus pushes expected responses, a monitor pops and compares each cycle.
module tb_decode_branch_unit;

    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_JMP  = 6'b000010;
    localparam logic [5:0] T_BC   = 6'b000011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, ins, rs_data;
    logic        br;
    logic [31:0] br_pc;
    logic [4:0]  rs_addr;
    logic        id_valid;
    logic [31:0] id_pc, id_ins, id_imm;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic [31:0] p;
        logic        chk_p;
        logic [31:0] i;
        logic        br;
        logic [31:0] bpc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    decode_branch_unit #(.SQUASH_SLOTS(2), .START_SKIP(1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ins(ins), .rs_data(rs_data),
        .br(br), .br_pc(br_pc), .rs_addr(rs_addr),
        .id_valid(id_valid), .id_pc(id_pc), .id_ins(id_ins),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .id_imm(id_imm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t ev(input logic v, input logic [31:0] p, input logic [31:0] i,
                                input logic b, input logic [31:0] bpc);
        exp_t e;
        e.v = v; e.p = p; e.chk_p = v; e.i = v ? i : 32'd0; e.br = b; e.bpc = bpc;
        return e;
    endfunction

    // One fetch slot per cycle; expectation describes the cycle after it.
    task automatic slot(input logic r, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] rsd, input exp_t e);
        logic [31:0] iv;
        @(negedge clk);
        rst = r; pc = p; ins = i; rs_data = rsd;
        iv = i;
        #1;
        chk("rs_addr", {27'd0, rs_addr}, {27'd0, iv[25:21]});
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("br", {31'd0, br}, {31'd0, e.br});
                chk("br_pc", br_pc, e.bpc);
                chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
                chk("id_ins", id_ins, e.i);
                if (e.chk_p) chk("id_pc", id_pc, e.p);
                chk("id_opcode", {26'd0, id_opcode}, {26'd0, e.i[31:26]});
                chk("id_rs", {27'd0, id_rs}, {27'd0, e.i[25:21]});
                chk("id_rt", {27'd0, id_rt}, {27'd0, e.i[20:16]});
                chk("id_rd", {27'd0, id_rd}, {27'd0, e.i[15:11]});
                chk("id_funct", {26'd0, id_funct}, {26'd0, e.i[5:0]});
                chk("id_imm", id_imm, {{16{e.i[15]}}, e.i[15:0]});
            end
        end
    end

    initial begin : stim
        exp_t rz;
        logic [31:0] a1, a2, jmp8, bc5, bc0, jmp20;
        rz = ev(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        rz.chk_p = 1'b1;
        rst = 1'b1; pc = 32'd0; ins = 32'd0; rs_data = 32'd0;
        a1    = mk(T_ADDI, 5'd1, 5'd2, 16'h0005);
        a2    = mk(T_ADDI, 5'd7, 5'd3, 16'h8001);
        jmp8  = {T_JMP, 26'd4};
        bc5   = mk(T_BC, 5'd9, 5'd0, 16'h0004);
        bc0   = mk(T_BC, 5'd4, 5'd0, 16'hFFFF);
        jmp20 = {T_JMP, 26'd7};

        // Reset values
        slot(1'b1, 32'd0, a1, 32'd0, rz);
        slot(1'b1, 32'd0, a1, 32'd0, rz);

        // Warm-up skip, then straight-line stream
        slot(1'b0, 32'd0, a1, 32'd0, ev(1'b0, 32'd0, a1, 1'b0, 32'd0));
        slot(1'b0, 32'd1, a1, 32'd0, ev(1'b1, 32'd1, a1, 1'b0, 32'd0));
        slot(1'b0, 32'd2, a2, 32'd0, ev(1'b1, 32'd2, a2, 1'b0, 32'd0));

        // JMP at pc 8 -> 4, two squashed slots
        slot(1'b0, 32'd8,  jmp8, 32'd0, ev(1'b1, 32'd8, jmp8, 1'b1, 32'd4));
        slot(1'b0, 32'd9,  a1,   32'd0, ev(1'b0, 32'd9, a1, 1'b0, 32'd4));
        slot(1'b0, 32'd10, a2,   32'd0, ev(1'b0, 32'd10, a2, 1'b0, 32'd4));
        slot(1'b0, 32'd4,  a2,   32'd0, ev(1'b1, 32'd4, a2, 1'b0, 32'd4));

        // Taken BC pc 5 + 4 = 9; JMPs inside the squash window are ignored
        slot(1'b0, 32'd5, bc5,  32'hFFFF_FFFF, ev(1'b1, 32'd5, bc5, 1'b1, 32'd9));
        slot(1'b0, 32'd6, jmp8, 32'd0, ev(1'b0, 32'd6, jmp8, 1'b0, 32'd9));
        slot(1'b0, 32'd7, jmp8, 32'd0, ev(1'b0, 32'd7, jmp8, 1'b0, 32'd9));
        slot(1'b0, 32'd9, a1,   32'd0, ev(1'b1, 32'd9, a1, 1'b0, 32'd9));

        // Not-taken BC: no redirect, no squash
        slot(1'b0, 32'd5, bc5, 32'd3, ev(1'b1, 32'd5, bc5, 1'b0, 32'd9));
        slot(1'b0, 32'd6, a2,  32'd0, ev(1'b1, 32'd6, a2, 1'b0, 32'd9));

        // BC wrap-around: 0 + (-1) = 0xFFFFFFFF
        slot(1'b0, 32'd0, bc0, 32'h8000_0000, ev(1'b1, 32'd0, bc0, 1'b1, 32'hFFFF_FFFF));
        slot(1'b0, 32'd1, a1,  32'd0, ev(1'b0, 32'd1, a1, 1'b0, 32'hFFFF_FFFF));
        slot(1'b0, 32'd2, jmp20, 32'd0, ev(1'b0, 32'd2, jmp20, 1'b0, 32'hFFFF_FFFF));
        slot(1'b0, 32'hFFFF_FFFF, a2, 32'd0, ev(1'b1, 32'hFFFF_FFFF, a2, 1'b0, 32'hFFFF_FFFF));

        // Reset while br is high wins; SKIP resumes afterwards
        slot(1'b0, 32'd20, jmp20, 32'd0, ev(1'b1, 32'd20, jmp20, 1'b1, 32'd7));
        slot(1'b1, 32'd7,  a1,    32'd0, rz);
        slot(1'b0, 32'd0,  a1,    32'd0, ev(1'b0, 32'd0, a1, 1'b0, 32'd0));
        slot(1'b0, 32'd1,  a2,    32'd0, ev(1'b1, 32'd1, a2, 1'b0, 32'd0));

        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_branch_unit.md
# decode_branch_unit

Instruction-decode stage that sits directly after the fetch stage and closes the fetch loop. It registers each incoming `pc`/`ins` pair into the IF/ID slot and decodes its fields for downstream stages. It resolves JMP and BC, returns a one-cycle `br`/`br_pc` redirect to fetch, and squashes the wrong-path instructions already in flight.

## Interface
Parameters:
- `SQUASH_SLOTS`, 2: number of fetched instructions discarded after a taken redirect.
- `START_SKIP`, 1: number of fetch slots ignored after reset release, covering the fetch warm-up cycle.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  word address of `ins`, from fetch.
- `ins`  in  32  instruction word, from fetch.
- `rs_data`  in  32  register-file read data for `rs_addr`, combinational.
- `br`  out  1  redirect request to fetch; one-cycle pulse.
- `br_pc`  out  32  redirect target, word address; valid while `br`=1.
- `rs_addr`  out  5  `ins[25:21]`, driven combinationally for the BC condition read.
- `id_valid`  out  1  the ID slot holds a live instruction.
- `id_pc`  out  32  PC of the ID-slot instruction.
- `id_ins`  out  32  ID-slot instruction; forced to 0 (NOP) when `id_valid`=0.
- `id_opcode`  out  6  `id_ins[31:26]`.
- `id_rs`, `id_rt`, `id_rd`  out  5 each  `id_ins[25:21]`, `[20:16]`, `[15:11]`.
- `id_funct`  out  6  `id_ins[5:0]`.
- `id_imm`  out  32  sign-extended `id_ins[15:0]`.

## Operation
- Opcodes: R-type 000000, JMP 000010, BC 000011, ADDI 001000, MVI 001001. Any other opcode passes through unchanged and does not redirect.
- JMP: taken unconditionally. `br_pc` = zero-extended `ins[25:0]`.
- BC: taken when `rs_data[31]`=1 (rs negative). `br_pc` = `pc` + sign-extended `ins[15:0]`, computed modulo 2^32 so wrap-around is ignored.
- FSM states: SKIP, RUN, SQUASH. A 2-bit counter `cnt` serves SKIP and SQUASH.
- Reset: state SKIP, `cnt`=START_SKIP, `br`=0, `br_pc`=0, `id_valid`=0, and all `id_*` outputs 0.
- SKIP: the incoming slot is discarded. When `cnt` reaches 1, go to RUN.
- RUN: the slot is captured with `id_valid`=1. If it is a taken JMP or BC, assert `br` next cycle, load `cnt`=SQUASH_SLOTS and go to SQUASH.
- SQUASH: the slot is discarded (`id_valid`=0, `id_ins`=0) and `br`=0. A JMP or BC inside a squashed slot is ignored. When `cnt` reaches 1, go to RUN.
- A not-taken BC behaves like a normal instruction: no redirect and no squash.
- `rst` asserted in any state, including mid-squash or while `br`=1, wins. It restores the reset values on the next edge.

## Timing
- Slot presented in cycle t: `id_*` and `br`/`br_pc` are registered and visible in cycle t+1. Decode-to-redirect latency is 1 cycle.
- `br` is high for exactly one cycle per taken branch; `br_pc` holds its value until the next redirect.
- Back-to-back redirects are impossible: a new `br` can occur no earlier than SQUASH_SLOTS+1 cycles after the previous one.
- The slots presented in cycles t+1 .. t+SQUASH_SLOTS are squashed. The first correct-path slot is expected at t+SQUASH_SLOTS+1.
- Only `rs_addr` is combinational from `ins`. The `rs_data`→`br` path ends in a flop.

## Structure
- Package `isa_pkg`:
  - opcode constants (OP_RTYPE, OP_JMP, OP_BC, OP_ADDI, OP_MVI);
  - FSM state enum;
  - field bit-position constants.
- Sub-module `branch_resolve`: combinational block that takes `pc`, `ins` and `rs_data` and produces `taken` and `target`. The top level contains the FSM, the counter and the IF/ID register.

## Test plan
- Reset then straight-line ADDI stream at pc 0,1,2: the slot at pc 0 is skipped; `id_valid`=1 with `id_pc`=1 then 2; `br` never asserts.
- JMP with imm26=4 at pc 8: next cycle `br`=1, `br_pc`=4; the following 2 slots (pc 9, 10) appear with `id_valid`=0 and `id_ins`=0; the slot after that (pc 4) has `id_valid`=1.
- BC at pc 5 with imm=4 and `rs_data`=0xFFFFFFFF: `br`=1, `br_pc`=9. Same instruction with `rs_data`=3: `br`=0 and there is no squash.
- BC at pc 0 with imm=0xFFFF and `rs_data` negative: `br_pc`=0xFFFFFFFF (wrap-around).
- JMP presented inside a squash slot: `br` stays 0 and the FSM returns to RUN after 2 slots.
- `rst` asserted on the cycle `br`=1: next cycle `br`=0, state SKIP, `id_valid`=0.
